// File: rtl/ram_log_ctrl.sv
// Capture controller that logs a sample stream into a BRAM, then replays it over a ready/valid stream.
// Optional macro RAM_LOG_DECIM_EN adds i_decim: only the first of every i_decim+1 valid samples is stored.
`timescale 1ns/1ps
module ram_log_ctrl #(
  parameter int NB_ADDR = 15,
  parameter int NB_DATA = 14
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_sample,
  input  logic               i_sample_valid,
  input  logic               i_read_req,
`ifdef RAM_LOG_DECIM_EN
  input  logic [3:0]         i_decim,
`endif
  output logic [NB_DATA-1:0] o_bram_wdata,
  output logic [NB_ADDR-1:0] o_bram_waddr,
  output logic               o_bram_we,
  output logic [NB_ADDR-1:0] o_bram_raddr,
  output logic               o_bram_re,
  input  logic [NB_DATA-1:0] i_bram_rdata,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_data_valid,
  input  logic               i_data_ready,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [2:0] {
    IDLE, CAPTURE, DONE, RD_ISSUE, RD_WAIT, RD_HOLD
  } state_t;

  localparam logic [NB_ADDR-1:0] LP_LAST = '1;
  localparam logic [NB_ADDR-1:0] LP_ONE  = NB_ADDR'(1);

  state_t             r_state;
  logic [NB_ADDR-1:0] r_wptr;
  logic [NB_ADDR-1:0] r_rptr;
  logic [NB_DATA-1:0] r_data;
  logic               r_valid;
  logic               r_re;
  logic               r_busy;
  logic               r_done;
  logic               w_accept;
  logic               w_we;

`ifdef RAM_LOG_DECIM_EN
  logic [3:0] r_decim_cnt;
  assign w_accept = i_sample_valid && (r_decim_cnt == 4'd0);
`else
  assign w_accept = i_sample_valid;
`endif

  // Write side is driven in the cycle the sample is presented; the state gate keeps it idle under reset.
  assign w_we         = (r_state == CAPTURE) && w_accept;
  assign o_bram_we    = w_we;
  assign o_bram_wdata = w_we ? i_sample : '0;
  assign o_bram_waddr = r_wptr;
  assign o_bram_raddr = r_rptr;
  assign o_bram_re    = r_re;
  assign o_data       = r_data;
  assign o_data_valid = r_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_re    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef RAM_LOG_DECIM_EN
      r_decim_cnt <= 4'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= CAPTURE;
            r_wptr  <= '0;
            r_busy  <= 1'b1;
`ifdef RAM_LOG_DECIM_EN
            r_decim_cnt <= 4'd0;
`endif
          end
        end
        CAPTURE: begin
`ifdef RAM_LOG_DECIM_EN
          if (i_sample_valid)
            r_decim_cnt <= (r_decim_cnt == i_decim) ? 4'd0 : r_decim_cnt + 4'd1;
`endif
          if (w_we) begin
            r_wptr <= r_wptr + LP_ONE;
            if (r_wptr == LP_LAST) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          // A restart takes priority over a readout request arriving in the same cycle.
          if (i_start) begin
            r_state <= CAPTURE;
            r_wptr  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
`ifdef RAM_LOG_DECIM_EN
            r_decim_cnt <= 4'd0;
`endif
          end else if (i_read_req) begin
            r_state <= RD_ISSUE;
            r_rptr  <= '0;
            r_re    <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        RD_ISSUE: begin
          r_re    <= 1'b0;
          r_state <= RD_WAIT;
        end
        RD_WAIT: begin
          r_data  <= i_bram_rdata;
          r_valid <= 1'b1;
          r_state <= RD_HOLD;
        end
        RD_HOLD: begin
          if (i_data_ready) begin
            r_valid <= 1'b0;
            if (r_rptr == LP_LAST) begin
              r_state <= IDLE;
              r_rptr  <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_rptr  <= r_rptr + LP_ONE;
              r_re    <= 1'b1;
              r_state <= RD_ISSUE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_log_ctrl.sv
// Randomized bench for ram_log_ctrl with a behavioural BRAM and an expected-log model.
`timescale 1ns/1ps
module tb_ram_log_ctrl;
  localparam int NA    = 4;
  localparam int ND    = 14;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_start = 1'b0;
  logic [ND-1:0] i_sample = '0;
  logic          i_sample_valid = 1'b0;
  logic          i_read_req = 1'b0;
  logic          i_data_ready = 1'b0;
  logic [ND-1:0] i_bram_rdata = '0;
  logic [ND-1:0] o_bram_wdata;
  logic [NA-1:0] o_bram_waddr;
  logic          o_bram_we;
  logic [NA-1:0] o_bram_raddr;
  logic          o_bram_re;
  logic [ND-1:0] o_data;
  logic          o_data_valid;
  logic          o_busy;
  logic          o_done;
`ifdef RAM_LOG_DECIM_EN
  logic [3:0]    i_decim = 4'd0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [ND-1:0] exp_mem [DEPTH];
  logic [ND-1:0] bram    [DEPTH];

  ram_log_ctrl #(.NB_ADDR(NA), .NB_DATA(ND)) dut (
    .clock          (clock),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .i_read_req     (i_read_req),
`ifdef RAM_LOG_DECIM_EN
    .i_decim        (i_decim),
`endif
    .o_bram_wdata   (o_bram_wdata),
    .o_bram_waddr   (o_bram_waddr),
    .o_bram_we      (o_bram_we),
    .o_bram_raddr   (o_bram_raddr),
    .o_bram_re      (o_bram_re),
    .i_bram_rdata   (i_bram_rdata),
    .o_data         (o_data),
    .o_data_valid   (o_data_valid),
    .i_data_ready   (i_data_ready),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 clock = ~clock;

  // BRAM with one-cycle registered read
  always @(posedge clock) begin
    if (o_bram_we) bram[o_bram_waddr] <= o_bram_wdata;
    if (o_bram_re) i_bram_rdata <= bram[o_bram_raddr];
  end

  always @(negedge clock) begin
    if (o_bram_we && o_bram_re) begin
      n_fail++;
      $display("FAIL we_re_exclusive: we=%0b re=%0b required not both 1", o_bram_we, o_bram_re);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_tests++;
    if ({o_busy, o_done, o_data_valid, o_bram_we, o_bram_re} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000", {o_busy, o_done, o_data_valid, o_bram_we, o_bram_re});
    end
    n_tests++;
    if ({o_data, o_bram_waddr, o_bram_raddr, o_bram_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_buses: data=%0d waddr=%0d raddr=%0d wdata=%0d required 0", o_data, o_bram_waddr, o_bram_raddr, o_bram_wdata);
    end
    @(posedge clock); #1;
    i_reset = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_ignore_idle();
    i_read_req = 1'b1;
    tick();
    i_read_req = 1'b0;
    @(negedge clock);
    n_tests++;
    if (o_busy !== 1'b0 || o_bram_re !== 1'b0 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_read_ignored: busy=%0b re=%0b done=%0b required 0 0 0", o_busy, o_bram_re, o_done);
    end
    $display("[TB] read_req in IDLE ignored check done");
  endtask

  // mode 0: start from IDLE/DONE; mode 1: start and read_req together from DONE
  task automatic test_capture(input int mode);
    int n;
    int gap;
    i_start = 1'b1;
    if (mode == 1) i_read_req = 1'b1;
    tick();
    i_start = 1'b0;
    i_read_req = 1'b0;
    @(negedge clock);
    n_tests++;
    if (o_busy !== 1'b1 || o_done !== 1'b0 || o_bram_re !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_entry: busy=%0b done=%0b re=%0b required 1 0 0", o_busy, o_done, o_bram_re);
    end
    tick();
    n = 0;
    while (n < DEPTH) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        i_sample_valid = 1'b0;
        @(negedge clock);
        n_tests++;
        if (o_bram_we !== 1'b0 || o_bram_re !== 1'b0) begin
          n_fail++;
          $display("FAIL capture_gap: we=%0b re=%0b required 0 0", o_bram_we, o_bram_re);
        end
        tick();
      end
      i_sample_valid = 1'b1;
      i_sample = ND'($urandom);
      // a mid-capture start/read request must not disturb the address sequence
      if (n == 8) begin
        i_start = 1'b1;
        i_read_req = 1'b1;
      end
      exp_mem[n] = i_sample;
      @(negedge clock);
      n_tests++;
      if (o_bram_we !== 1'b1 || o_bram_waddr !== NA'(n) || o_bram_wdata !== exp_mem[n]) begin
        n_fail++;
        $display("FAIL capture_write: we=%0b addr=%0d data=%0d required 1 %0d %0d", o_bram_we, o_bram_waddr, o_bram_wdata, n, exp_mem[n]);
      end
      tick();
      i_start = 1'b0;
      i_read_req = 1'b0;
      n++;
    end
    i_sample = ND'($urandom);
    @(negedge clock);
    n_tests++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_bram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_done: done=%0b busy=%0b we(17th)=%0b required 1 0 0", o_done, o_busy, o_bram_we);
    end
    tick();
    i_sample_valid = 1'b0;
    $display("[TB] capture mode %0d: %0d samples logged", mode, n);
  endtask

  // mode 0: always ready; mode 1: stall 5 cycles on word 3; mode 2: random ready
  task automatic test_readout(input int mode);
    int idx;
    int stall;
    int cycles;
    idx = 0;
    stall = 0;
    cycles = 0;
    i_read_req = 1'b1;
    tick();
    i_read_req = 1'b0;
    while (idx < DEPTH && cycles < 400) begin
      case (mode)
        0: i_data_ready = 1'b1;
        1: i_data_ready = (idx == 3 && stall < 5) ? 1'b0 : 1'b1;
        default: i_data_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clock);
      if (o_data_valid) begin
        n_tests++;
        if (o_data !== exp_mem[idx]) begin
          n_fail++;
          $display("FAIL readout_word: idx=%0d got %0d required %0d", idx, o_data, exp_mem[idx]);
        end
        if (mode == 1 && idx == 3 && !i_data_ready) stall++;
        if (i_data_ready) idx++;
      end
      tick();
      cycles++;
    end
    i_data_ready = 1'b0;
    n_tests++;
    if (idx != DEPTH) begin
      n_fail++;
      $display("FAIL readout_timeout: consumed %0d required %0d", idx, DEPTH);
    end
    if (mode != 2) begin
      n_tests++;
      if (cycles != 3 * DEPTH + ((mode == 1) ? 5 : 0)) begin
        n_fail++;
        $display("FAIL readout_cycles: got %0d required %0d", cycles, 3 * DEPTH + ((mode == 1) ? 5 : 0));
      end
    end
    if (mode == 1) begin
      n_tests++;
      if (stall != 5) begin
        n_fail++;
        $display("FAIL readout_stall: held cycles %0d required 5", stall);
      end
    end
    @(negedge clock);
    n_tests++;
    if (o_data_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL readout_end: valid=%0b busy=%0b done=%0b required 0 0 0", o_data_valid, o_busy, o_done);
    end
    tick();
    $display("[TB] readout mode %0d: %0d words in %0d cycles", mode, idx, cycles);
  endtask

  task automatic test_reset_mid_capture();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      i_sample_valid = 1'b1;
      i_sample = ND'($urandom);
      @(negedge clock);
      n_tests++;
      if (o_bram_we !== 1'b1 || o_bram_waddr !== NA'(k)) begin
        n_fail++;
        $display("FAIL abort_prefix: we=%0b addr=%0d required 1 %0d", o_bram_we, o_bram_waddr, k);
      end
      tick();
    end
    i_sample = ND'($urandom);
    i_reset = 1'b0;
    #1;
    n_tests++;
    if ({o_busy, o_done, o_data_valid, o_bram_we, o_bram_re} !== 5'b0 || o_bram_waddr !== '0 || o_bram_wdata !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: flags=%b waddr=%0d wdata=%0d required 0", {o_busy, o_done, o_data_valid, o_bram_we, o_bram_re}, o_bram_waddr, o_bram_wdata);
    end
    @(negedge clock);
    n_tests++;
    if (o_bram_we !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_hold: we=%0b busy=%0b required 0 0", o_bram_we, o_busy);
    end
    i_sample_valid = 1'b0;
    tick();
    i_reset = 1'b1;
    tick();
    $display("[TB] reset at capture word 7 aborted capture");
  endtask

`ifdef RAM_LOG_DECIM_EN
  task automatic test_decim();
    int k;
    int stored;
    i_decim = 4'd2;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    k = 0;
    stored = 0;
    while (stored < DEPTH && k < 200) begin
      if ($urandom_range(0, 3) == 0) begin
        i_sample_valid = 1'b0;
        tick();
      end
      i_sample_valid = 1'b1;
      i_sample = ND'(k);
      @(negedge clock);
      n_tests++;
      if (o_bram_we !== ((k % 3) == 0) || (o_bram_we && (o_bram_waddr !== NA'(k / 3) || o_bram_wdata !== ND'(k)))) begin
        n_fail++;
        $display("FAIL decim_write: k=%0d we=%0b addr=%0d data=%0d", k, o_bram_we, o_bram_waddr, o_bram_wdata);
      end
      if ((k % 3) == 0) stored++;
      tick();
      k++;
    end
    i_sample_valid = 1'b0;
    @(negedge clock);
    n_tests++;
    if (o_done !== 1'b1) begin
      n_fail++;
      $display("FAIL decim_done: done=%0b required 1", o_done);
    end
    i_decim = 4'd0;
    tick();
    $display("[TB] decimation by 3: %0d words stored", stored);
  endtask
`endif

  initial begin
    test_reset();
    test_ignore_idle();
    test_capture(0);
    test_readout(0);
    test_capture(0);
    test_readout(1);
    test_capture(0);
    test_readout(2);
    test_reset_mid_capture();
    test_capture(0);
    test_capture(1);
    test_readout(0);
`ifdef RAM_LOG_DECIM_EN
    test_decim();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
